// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiply sequencer for the EX stage.
// Stalls the pipeline while iterating; early-exits once the multiplier runs out of set bits.
module mul_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mplier_sh;
  logic [CW-1:0]      count;
  logic               accept;
  logic               last;

  assign mplier_sh = mplier >> 1;
  assign accept    = (state == IDLE) & start & ~flush;
  assign last      = (mplier_sh == '0) | (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: begin
        if (flush)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A flushed iteration leaves acc untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (state == RUN && !flush) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier_sh;
      count  <= count + 1'b1;
    end
  end

  assign stall     = accept | (state == RUN);
  assign busy      = (state == RUN) | (state == DONE);
  assign done      = (state == DONE);
  assign result_lo = acc[WIDTH-1:0];
  assign result_hi = acc[2*WIDTH-1:WIDTH];

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiply controller for the EX stage of the pipelined core. When the ALU control path decodes a multiply, this block takes both operands, runs a radix-2 shift-add loop over several cycles and holds the pipeline via `stall` until the product is ready. It then presents the full 2×WIDTH unsigned product for one-cycle capture into EX/MEM. Single-cycle ALU operations bypass it entirely.

## Interface
- `WIDTH`, 64, operand width in bits; product is 2×WIDTH.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  multiply request from EX decode; sampled in IDLE only.
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `a`  in  WIDTH  multiplicand, unsigned; sampled on accepted start.
- `b`  in  WIDTH  multiplier, unsigned; sampled on accepted start.
- `stall`  out  1  holds IF/ID/EX while a multiply is pending.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; product valid this cycle.
- `result_lo`  out  WIDTH  low half of product.
- `result_hi`  out  WIDTH  high half of product.

## Operation
- States: IDLE, RUN, DONE. Internal registers: `mcand` (2×WIDTH), `mplier` (WIDTH), `acc` (2×WIDTH), `count` (log2 WIDTH bits).
- IDLE: `start`=1 and `flush`=0 -> load `mcand`={WIDTH'0,a}, `mplier`=b, `acc`=0, `count`=0; go to RUN.
- RUN, each cycle:
  - if `mplier[0]`, then `acc` <= `acc`+`mcand`, modulo 2^(2×WIDTH). No overflow is possible.
  - `mcand` <= `mcand`<<1; `mplier` <= `mplier`>>1; `count`++.
  - Go to DONE when the shifted `mplier` is 0 (early termination) or `count`==WIDTH-1. Otherwise stay in RUN.
- RUN length = max(1, index of highest set bit of b + 1) cycles.
- DONE: `done`=1, `{result_hi,result_lo}`=`acc`. Next state is IDLE unconditionally.
- `start` in RUN or DONE is ignored. No queueing.
- `flush`=1 in any state -> IDLE at the next edge. No `done` pulse. `acc` keeps its last value. Flush has priority over start and over the RUN→DONE transition.
- `stall` = (IDLE & `start` & !`flush`) | RUN. It is combinational, so the multiply instruction is held in EX from its first cycle. `stall`=0 in DONE so the pipeline advances and captures the result.
- `result_hi`/`result_lo` are driven from `acc` at all times and hold until the next accepted start clears `acc`.

## Timing
- Reset (`rst_n`=0, any time, including mid-RUN): state=IDLE, `acc`=0, `count`=0, `mcand`=0, `mplier`=0. Outputs: `stall`=0, `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0. These values are reached immediately, without waiting for a clock edge.
- Start accepted at edge E0. RUN occupies edges E1..En, where n = RUN length. DONE is the cycle after En. Latency from start to `done` = n+1 cycles, which is 2 for b∈{0,1} and WIDTH+1 for b[WIDTH-1]=1.
- `stall` is high from the start cycle through the last RUN cycle inclusive, and low in DONE.
- Back-to-back multiplies: the earliest following start is accepted in the IDLE cycle after DONE.
- `a` and `b` may change freely after the accepting edge.

## Test plan
- Reset, then `start` with a=3, b=5 -> stall high for 4 cycles (start cycle + 3 RUN), then `done`=1 with `result_lo`=15, `result_hi`=0. Next cycle is IDLE.
- a=0x1234, b=0 -> RUN for 1 cycle; `done` on the 2nd cycle after start with result 0.
- a=b=0xFFFF_FFFF_FFFF_FFFF -> 64 RUN cycles; `done` at cycle 65 with `result_hi`=0xFFFF_FFFF_FFFF_FFFE and `result_lo`=0x0000_0000_0000_0001.
- a=7, b=0x80 with `flush` pulsed on the 4th RUN cycle -> IDLE next cycle, no `done`, `stall` drops. Then a=6, b=7 -> result 42 with correct latency (4 cycles to `done`).
- `rst_n` asserted low mid-RUN (a=9, b=0xFF) -> all outputs 0 immediately. After release, a=2, b=2 completes as 4.
- `start` held high across RUN and DONE -> only the first request executes. A second multiply with the new operands is accepted in the following IDLE cycle and completes correctly.
